// File: rtl/cla_seq_adder.sv
// Sequential 16-bit carry-lookahead adder: one 4-bit lookahead nibble per clock.
// Optional signed-overflow output is compiled in when CLA_SEQ_OVF_EN is defined.
module cla_seq_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic        ready,
    output logic        done,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        group_g,
    output logic        group_p
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_sum;
    logic        r_carry;
    logic        r_grp_g;
    logic        r_grp_p;
    logic        r_ready;
    logic        r_done;
`ifdef CLA_SEQ_OVF_EN
    logic        r_ovf;
`endif

    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic [3:0]  w_g;
    logic [3:0]  w_p;
    logic [3:0]  w_c;
    logic [3:0]  w_sum_nib;
    logic        w_gn;
    logic        w_pn;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit_terms
            assign w_g[gi] = w_a_nib[gi] & w_b_nib[gi];
            assign w_p[gi] = w_a_nib[gi] ^ w_b_nib[gi];
        end
    endgenerate

    // Flat two-level lookahead: every carry depends only on g/p and the running carry.
    assign w_c[0] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_gn   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_pn   = &w_p;
    assign w_c[3] = w_gn | (w_pn & r_carry);

    assign w_sum_nib = w_p ^ {w_c[2:0], r_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_a     <= 16'd0;
            r_b     <= 16'd0;
            r_sum   <= 16'd0;
            r_carry <= 1'b0;
            r_grp_g <= 1'b0;
            r_grp_p <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= 2'd0;
                        r_grp_g <= 1'b0;
                        r_grp_p <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_sum_nib;
                    r_carry <= w_c[3];
                    // Lower nibbles already folded in, so the new nibble sits on the left.
                    r_grp_g <= w_gn | (w_pn & r_grp_g);
                    r_grp_p <= w_pn & r_grp_p;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`ifdef CLA_SEQ_OVF_EN
                        r_ovf   <= w_c[2] ^ w_c[3];
`endif
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign done    = r_done;
    assign sum     = r_sum;
    assign c_out   = r_carry;
    assign group_g = r_grp_g;
    assign group_p = r_grp_p;
`ifdef CLA_SEQ_OVF_EN
    assign ovf     = r_ovf;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: driver pushes arithmetic-model results,
// a negedge monitor pops and compares on every done pulse.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        group_g;
    logic        group_p;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf;
`endif

    cla_seq_adder dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .c_in    (cin_i),
        .ready   (ready),
        .done    (done),
        .sum     (sum),
        .c_out   (c_out),
        .group_g (group_g),
        .group_p (group_p)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        g;
        logic        p;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t last_e;
    bit   have_last = 0;
    bit   prev_done = 0;
    bit   b2b_mode = 0;
    int   last_done_cyc = -1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain 17-bit arithmetic plus sign-rule overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input int acc);
        exp_t e;
        logic [16:0] t;
        logic [16:0] t0;
        t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        t0 = {1'b0, a} + {1'b0, b};
        e.a    = a;
        e.b    = b;
        e.cin  = cin;
        e.sum  = t[15:0];
        e.cout = t[16];
        e.g    = t0[16];
        e.p    = ((a ^ b) == 16'hFFFF);
        e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        e.acc  = acc;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    // Issue one request at a negedge; returns at the negedge after acceptance.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input bit push);
        wait_ready();
        a_i   = a;
        b_i   = b;
        cin_i = cin;
        start = 1'b1;
        if (push) sb_q.push_back(model(a, b, cin, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (prev_done) check("done_width", 32'd1, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb_q.pop_front();
                check("latency", cyc - mon_e.acc, 32'd4);
                check("sum", {16'd0, sum}, {16'd0, mon_e.sum});
                check("c_out", {31'd0, c_out}, {31'd0, mon_e.cout});
                check("group_g", {31'd0, group_g}, {31'd0, mon_e.g});
                check("group_p", {31'd0, group_p}, {31'd0, mon_e.p});
`ifdef CLA_SEQ_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
                if (b2b_mode && last_done_cyc >= 0)
                    check("b2b_period", cyc - last_done_cyc, 32'd6);
                last_done_cyc = cyc;
                $display("op a=%h b=%h cin=%0d -> sum=%h c_out=%0d g=%0d p=%0d (model sum=%h c_out=%0d)",
                         mon_e.a, mon_e.b, mon_e.cin, sum, c_out, group_g, group_p,
                         mon_e.sum, mon_e.cout);
                last_e    = mon_e;
                have_last = 1;
            end
        end else if (ready === 1'b1 && have_last) begin
            check("hold_sum", {16'd0, sum}, {16'd0, last_e.sum});
            check("hold_c_out", {31'd0, c_out}, {31'd0, last_e.cout});
            check("hold_g", {31'd0, group_g}, {31'd0, last_e.g});
            check("hold_p", {31'd0, group_p}, {31'd0, last_e.p});
        end
        prev_done = (done === 1'b1);
    end

    task automatic expect_cleared(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sum"}, {16'd0, sum}, 32'd0);
        check({tag, "_c_out"}, {31'd0, c_out}, 32'd0);
        check({tag, "_g"}, {31'd0, group_g}, 32'd0);
        check({tag, "_p"}, {31'd0, group_p}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_i   = 16'd0;
        b_i   = 16'd0;
        cin_i = 1'b0;
        repeat (3) @(negedge clk);
        expect_cleared("reset");
        last_e    = model(16'd0, 16'd0, 1'b0, 0);
        last_e.p  = 1'b0;
        have_last = 1;
        rst = 1'b0;
        @(negedge clk);

        do_op(16'hFFFF, 16'h0001, 1'b0, 1);
        do_op(16'h1234, 16'h4321, 1'b1, 1);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1);
        do_op(16'h8000, 16'h8000, 1'b0, 1);

        for (int i = 0; i < 20; i++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1);

        // Second request while busy must be dropped.
        do_op(16'h00F0, 16'h0F0F, 1'b1, 1);
        @(negedge clk);
        a_i   = 16'hDEAD;
        b_i   = 16'hBEEF;
        cin_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Abort in the second RUN cycle: no done may follow.
        do_op(16'hAAAA, 16'h5555, 1'b1, 0);
        @(negedge clk);
        rst       = 1'b1;
        last_e    = model(16'd0, 16'd0, 1'b0, 0);
        last_e.p  = 1'b0;
        @(negedge clk);
        expect_cleared("abort");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1);

        // start held high: operations every 6 cycles.
        wait_ready();
        b2b_mode      = 1;
        last_done_cyc = -1;
        begin
            int n = 0;
            int guard = 0;
            start = 1'b1;
            while (n < 5 && guard < 100) begin
                if (ready === 1'b1) begin
                    a_i   = 16'($urandom);
                    b_i   = 16'($urandom);
                    cin_i = 1'($urandom_range(0, 1));
                    sb_q.push_back(model(a_i, b_i, cin_i, cyc + 1));
                    n++;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            check("b2b_issued", n, 32'd5);
        end
        wait_ready();
        b2b_mode = 0;

        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when ready=1
- a  in  16  operand A
- b  in  16  operand B
- c_in  in  1  carry into bit 0
- ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- sum  out  16  result
- c_out  out  1  carry out of bit 15
- group_g  out  1  16-bit group generate
- group_p  out  1  16-bit group propagate
- ovf  out  1  signed overflow; present only when CLA_SEQ_OVF_EN is defined
REQ-003 The block SHALL have no parameters; the width is fixed at 16 bits, processed as 4 nibbles.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 In IDLE, start=1 at an edge SHALL latch a, b and c_in, clear the nibble index to 0, and move the FSM to RUN.
REQ-006 In RUN, each edge SHALL process one nibble i, from 0 to 3.
REQ-007 For nibble i, the bit-level terms SHALL be g=a&b and p=a^b.
REQ-008 The four bit carries of nibble i SHALL come from 4-bit lookahead equations (c[k] = g[k] | p[k]&c[k-1] ...), seeded by the running carry.
REQ-009 Nibble i of sum SHALL be p ^ {c[2:0], carry_in_i}.
REQ-010 The running carry SHALL be updated to c[3] of nibble i.
REQ-011 The nibble group generate and propagate SHALL accumulate as G <= Gn | (Pn & G) and P <= Pn & P, starting from G=0 and P=1.
REQ-012 After nibble 3 is processed, the FSM SHALL move to DONE; done SHALL then be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-013 Latency: start accepted at edge k SHALL produce done=1 during the cycle after edge k+4; at most one operation SHALL be in flight.
REQ-014 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation.
REQ-015 sum, c_out, group_g and group_p SHALL be valid while done=1.
REQ-016 These outputs SHALL hold their values until the next accepted start.
REQ-017 Partial values of sum are visible during RUN and are don't-care.
REQ-018 c_out SHALL equal the final running carry; group_g and group_p SHALL equal the accumulated G and P, both independent of c_in.
REQ-019 Wrap-around: the result SHALL be modulo 2^16, with the 17th bit reported only on c_out.
REQ-020 start held continuously SHALL give back-to-back operations every 6 cycles (IDLE, 4×RUN, DONE).

Reset
REQ-021 rst=1 SHALL force state IDLE, nibble index 0, sum=0, c_out=0, group_g=0, group_p=0, done=0, ovf=0 and ready=1 in the following cycle.
REQ-022 rst SHALL take priority over start.
REQ-023 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-024 The macro CLA_SEQ_OVF_EN SHALL control the overflow feature.
REQ-025 With CLA_SEQ_OVF_EN defined, the ovf port SHALL exist and equal (carry into bit 15) XOR (carry out of bit 15), registered together with nibble 3 and valid while done=1.
REQ-026 Without CLA_SEQ_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, group_g=1, group_p=0, with done exactly 4 cycles after acceptance.
REQ-028 The bench SHALL cover a=0x1234, b=0x4321, c_in=1 -> sum=0x5556, c_out=0, group_g=0, group_p=0.
REQ-029 The bench SHALL cover a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, group_g=0, group_p=1.
REQ-030 The bench SHALL cover, with CLA_SEQ_OVF_EN defined, a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1; and a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
REQ-031 The bench SHALL cover a start pulse with new operands during RUN -> ignored, and the first result is unchanged.
REQ-032 The bench SHALL cover rst asserted in the second RUN cycle -> no done, all outputs 0, ready=1 next cycle; a following start SHALL complete normally.
